// File: rtl/alu_arbiter.sv
// Two-client round-robin arbiter and sequencer for the shared ALU.
// One operation in flight at a time: accept -> ISSUE (drive ALU) -> RESP (return result).
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2:0]       req_op0,
    input  logic [2:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    logic             last;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] res_r;
    logic             grant;
    logic             accept;

    // Round-robin grant: only in IDLE; on contention the client that did not win last time goes first
    always_comb begin
        grant     = 1'b0;
        accept    = 1'b0;
        req_ready = 2'b00;
        if (state == IDLE) begin
            accept = |req_valid;
            case (req_valid)
                2'b01:   grant = 1'b0;
                2'b10:   grant = 1'b1;
                2'b11:   grant = ~last;
                default: grant = 1'b0;
            endcase
            if (accept) begin
                req_ready = grant ? 2'b10 : 2'b01;
            end
        end
    end

    // Sequencer FSM: latches the granted request, samples the ALU in ISSUE, holds the response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= 1'b1;
            owner     <= 1'b0;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            res_r     <= '0;
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last  <= grant;
                        owner <= grant;
                        op_r  <= grant ? req_op1 : req_op0;
                        a_r   <= grant ? req_a1  : req_a0;
                        b_r   <= grant ? req_b1  : req_b0;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    res_r     <= alu_result;
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 2'b00;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign alu_op   = op_r;
    assign alu_a    = a_r;
    assign alu_b    = b_r;
    assign rsp_data = res_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run
// compared every cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [2:0]   req_op0, req_op1;
    logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [W-1:0] rsp_data;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         busy, owner;

    int checks = 0;
    int passes = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .busy(busy), .owner(owner)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Stand-in ALU: code k selects option k+1
    function automatic logic [W-1:0] aluModel(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a ^ b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return a << 1;
            3'd6: return a >> 1;
            default: return p[W-1:0];
        endcase
    endfunction

    assign alu_result = aluModel(alu_op, alu_a, alu_b);

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [2:0] o0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                                 input logic [2:0] o1, input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [1:0] rr);
        req_valid = v;
        req_op0 = o0; req_a0 = a0; req_b0 = b0;
        req_op1 = o1; req_a1 = a1; req_b1 = b1;
        rsp_ready = rr;
    endtask

    // Reference model: transaction phase (0 idle, 1 issuing, 2 responding) and the captured request
    int           mPhase;
    logic         mLast, mOwner;
    logic [2:0]   mOp;
    logic [W-1:0] mA, mB, mPend, mRes;

    function automatic logic modelGrant(input logic [1:0] v, input logic lastWinner);
        if (v == 2'b11) return !lastWinner;
        return v[1];
    endfunction

    // Model advances on each clock edge using the inputs that were stable before it
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase <= 0; mLast <= 1'b1; mOwner <= 1'b0;
            mOp <= '0; mA <= '0; mB <= '0; mPend <= '0; mRes <= '0;
        end else begin
            if (mPhase == 0) begin
                if (req_valid != 2'b00) begin
                    mLast  <= modelGrant(req_valid, mLast);
                    mOwner <= modelGrant(req_valid, mLast);
                    mOp    <= modelGrant(req_valid, mLast) ? req_op1 : req_op0;
                    mA     <= modelGrant(req_valid, mLast) ? req_a1 : req_a0;
                    mB     <= modelGrant(req_valid, mLast) ? req_b1 : req_b0;
                    mPend  <= modelGrant(req_valid, mLast) ? aluModel(req_op1, req_a1, req_b1)
                                                           : aluModel(req_op0, req_a0, req_b0);
                    mPhase <= 1;
                end
            end else if (mPhase == 1) begin
                mRes   <= mPend;
                mPhase <= 2;
            end else if (rsp_ready[mOwner]) begin
                mPhase <= 0;
            end
        end
    end

    logic [1:0] expReady, expValid;

    // Compare the DUT against the model mid-cycle whenever reset is released
    always @(negedge clk) begin
        if (rst_n) begin
            expReady = (mPhase == 0 && req_valid != 2'b00) ? (modelGrant(req_valid, mLast) ? 2'b10 : 2'b01) : 2'b00;
            expValid = (mPhase == 2) ? (mOwner ? 2'b10 : 2'b01) : 2'b00;
            checkOutput("model req_ready", 32'(req_ready), 32'(expReady));
            checkOutput("model rsp_valid", 32'(rsp_valid), 32'(expValid));
            checkOutput("model busy", 32'(busy), 32'(mPhase != 0));
            checkOutput("model owner", 32'(owner), 32'(mOwner));
            checkOutput("model alu_op", 32'(alu_op), 32'(mOp));
            checkOutput("model alu_a", 32'(alu_a), 32'(mA));
            checkOutput("model alu_b", 32'(alu_b), 32'(mB));
            if (mPhase == 2) checkOutput("model rsp_data", 32'(rsp_data), 32'(mRes));
        end
    end

    // Bound on total run time
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    int           grants[$];
    int           acceptCycles[$];
    logic [W-1:0] expData;
    logic [W-1:0] heldData;

    // Directed scenarios followed by randomized traffic
    initial begin
        rst_n = 1'b0;
        applyStimulus(2'b00, 3'd0, '0, '0, 3'd0, '0, '0, 2'b11);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset alu_op", 32'(alu_op), 32'd0);
        checkOutput("reset alu_a", 32'(alu_a), 32'd0);
        checkOutput("reset alu_b", 32'(alu_b), 32'd0);
        checkOutput("reset rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("reset owner", 32'(owner), 32'd0);
        checkOutput("reset req_ready idle", 32'(req_ready), 32'd0);
        req_valid = 2'b01;
        #1;
        checkOutput("reset req_ready with valid", 32'(req_ready), 32'h1);
        req_valid = 2'b00;
        #1;
        rst_n = 1'b1;

        // Client 0 alone, XOR
        @(posedge clk); #1;
        applyStimulus(2'b01, 3'd2, 16'h1234, 16'h0F0F, 3'd0, '0, '0, 2'b11);
        @(negedge clk);
        checkOutput("xor req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checkOutput("xor issue alu_op", 32'(alu_op), 32'd2);
        checkOutput("xor issue alu_a", 32'(alu_a), 32'h1234);
        checkOutput("xor issue alu_b", 32'(alu_b), 32'h0F0F);
        @(negedge clk);
        checkOutput("xor rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("xor rsp_data", 32'(rsp_data), 32'h1D3B);
        @(posedge clk); #1;

        // Constant contention straight out of reset
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        applyStimulus(2'b11, 3'($urandom), 16'($urandom), 16'($urandom),
                      3'($urandom), 16'($urandom), 16'($urandom), 2'b11);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                grants.push_back(int'(req_ready[1]));
                acceptCycles.push_back(i);
            end
            @(posedge clk); #1;
            applyStimulus(2'b11, 3'($urandom), 16'($urandom), 16'($urandom),
                          3'($urandom), 16'($urandom), 16'($urandom), 2'b11);
        end
        req_valid = 2'b00;
        checkOutput("contention grant count", 32'(grants.size()), 32'd4);
        for (int k = 0; k < grants.size() && k < 4; k++) begin
            checkOutput($sformatf("contention grant %0d", k), 32'(grants[k]), 32'(k % 2));
            checkOutput($sformatf("contention cycle %0d", k), 32'(acceptCycles[k]), 32'(3 * k));
        end

        // Backpressure on a client-0 response while client 1 waits
        applyStimulus(2'b01, 3'($urandom), 16'($urandom), 16'($urandom), 3'd4, 16'h00F0, 16'h0F00, 2'b11);
        expData = aluModel(req_op0, req_a0, req_b0);
        @(negedge clk);
        checkOutput("bp req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b10;
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        heldData = rsp_data;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) rsp_ready = 2'b11;
            @(negedge clk);
            checkOutput("bp rsp_valid", 32'(rsp_valid), 32'h1);
            checkOutput("bp rsp_data", 32'(rsp_data), 32'(expData));
            checkOutput("bp rsp_data stable", 32'(rsp_data), 32'(heldData));
            checkOutput("bp req_ready[1]", 32'(req_ready[1]), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        checkOutput("bp late grant", 32'(req_ready), 32'h2);

        // Response ready from the wrong client is ignored
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("wrong ready rsp_valid", 32'(rsp_valid), 32'h2);
            checkOutput("wrong ready busy", 32'(busy), 32'd1);
            checkOutput("wrong ready rsp_data", 32'(rsp_data), 32'h0FF0);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        checkOutput("owner ready rsp_valid", 32'(rsp_valid), 32'h2);
        @(negedge clk);
        checkOutput("owner ready done busy", 32'(busy), 32'd0);
        checkOutput("owner ready done rsp_valid", 32'(rsp_valid), 32'd0);

        // Edge op code and all-ones operands
        @(posedge clk); #1;
        applyStimulus(2'b01, 3'd7, 16'hFFFF, 16'hFFFF, 3'd0, '0, '0, 2'b11);
        @(negedge clk);
        checkOutput("edge req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checkOutput("edge alu_op", 32'(alu_op), 32'd7);
        checkOutput("edge alu_a", 32'(alu_a), 32'hFFFF);
        checkOutput("edge alu_b", 32'(alu_b), 32'hFFFF);
        @(negedge clk);
        checkOutput("edge rsp_data", 32'(rsp_data), 32'h0001);
        @(posedge clk); #1;

        // Reset dropped during ISSUE of a client-0 request
        applyStimulus(2'b01, 3'd5, 16'hABCD, 16'h1111, 3'd0, '0, '0, 2'b11);
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("mid reset alu_op", 32'(alu_op), 32'd0);
        checkOutput("mid reset alu_a", 32'(alu_a), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post reset rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        applyStimulus(2'b11, 3'($urandom), 16'($urandom), 16'($urandom),
                      3'($urandom), 16'($urandom), 16'($urandom), 2'b11);
        @(negedge clk);
        checkOutput("post reset contention", 32'(req_ready), 32'h1);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            applyStimulus(2'($urandom), 3'($urandom), 16'($urandom), 16'($urandom),
                          3'($urandom), 16'($urandom), 16'($urandom),
                          {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
